icache_direct: RTL
==================

# icache_direct

Direct-mapped, read-only, blocking instruction cache between the IF stage's program counter and instruction port A of the external memory. It answers fetches combinationally on a hit. On a miss it raises `stall`, the pipeline's ICacheStall, and refills one full line from the synchronous block RAM. It also supports a whole-cache invalidate and keeps hit/miss performance counters.

## Interface
Parameters:
- `LINES`, default 16: number of lines; power of two.
- `WORDS`, default 4: 32-bit words per line; power of two, ≥2.
- `NOP`, default 32'h0000_0013: word driven on `inst_out` when not hitting.

Ports:
- `clk` in 1: the single clock.
- `rst` in 1: reset, asynchronous, active-high.
- `req` in 1: fetch request valid.
- `pc_in` in 32: fetch address; bits [1:0] ignored.
- `flush` in 1: invalidate all lines.
- `inst_out` out 32: fetched instruction.
- `stall` out 1: fetch not satisfied this cycle; freezes PC and IF_ID.
- `mem_addr` out 32: word address to memory port A (registered).
- `mem_rd_en` out 1: read issued this cycle (registered).
- `mem_data` in 32: memory read data, valid exactly 1 cycle after the matching `mem_rd_en`.
- `hit_count` out 32: saturating hit counter.
- `miss_count` out 32: saturating miss counter.

## Operation
- Address split: offset = pc[log2(WORDS)+1:2]; index = next log2(LINES) bits; tag = remaining upper bits. Defaults: offset [3:2], index [7:4], tag [31:8].
- Storage per line: valid bit, tag, WORDS data words. Only `valid` is reset; tag and data are undefined after reset.
- hit = req & state==IDLE & valid[index] & tag match.
- `inst_out` = selected word on hit, else NOP.
- `stall` = req & ~hit.
- FSM states: IDLE, REFILL, LAST.
  - IDLE: on req & miss & ~flush, latch base = {pc tag, index, 0 offset}, increment miss_count, go to REFILL with issue counter = 0. On hit, increment hit_count.
  - REFILL: drive mem_rd_en=1 and mem_addr = base + 4·issue counter. Write mem_data from the previous issue into word (issue counter−1). After WORDS issues, go to LAST.
  - LAST: mem_rd_en=0; write the final word; set the line's valid bit and tag from base; go to IDLE.
- `pc_in` and `req` are ignored outside IDLE. The latched line always completes, even if the PC is redirected. The new PC is looked up on return to IDLE and may miss again.
- Flush:
  - In IDLE: all valid bits clear at the clock edge. The same-cycle lookup is treated as a miss but starts no refill; it re-looks up next cycle.
  - In REFILL or LAST: the refill aborts. Next state is IDLE, mem_rd_en=0, in-flight data is discarded, all valid bits clear, and the aborted line stays invalid.
- Counters saturate at 32'hFFFF_FFFF. No increment when req=0.

## Timing
- Reset values (asserted asynchronously, independent of clk): state IDLE, all valid=0, mem_rd_en=0, mem_addr=0, hit_count=0, miss_count=0.
  - inst_out=NOP.
  - stall = req (every line is invalid).
- Hit: 0-cycle latency; inst_out is valid in the same cycle as pc_in.
- Miss penalty with miss detected at cycle t:
  - REFILL occupies cycles t+1..t+WORDS.
  - LAST at t+WORDS+1.
  - Hit and stall=0 at t+WORDS+2 if pc_in is unchanged.
  - Total stall cycles = WORDS+2 (6 at default).
- mem_addr increments by 4 each REFILL cycle. It holds its last value in LAST/IDLE.
- Reset mid-refill: the FSM returns to IDLE at once and valid bits clear. The partial line is lost.

## Test plan
Memory model: word at address A = A + 32'h1000, 1-cycle latency. Default parameters throughout.
- Cold miss: reset, then req=1, pc=0x100 → stall=1 for 6 cycles; mem_addr 0x100, 0x104, 0x108, 0x10C on consecutive mem_rd_en cycles; then inst_out=0x1100, stall=0, miss_count=1.
- Sequential hits: continue pc=0x104, 0x108, 0x10C → stall=0 each cycle; inst_out=0x1104, 0x1108, 0x110C; hit_count=4.
- Conflict eviction: pc=0x200 (index 0) → miss and refill, inst_out=0x1200. Then pc=0x100 → miss again; miss_count=3.
- Redirect during refill: miss at 0x100, pc changed to 0x140 in the 2nd REFILL cycle → all four 0x100-line reads still issue. Then 0x140 misses, refills 0x140–0x14C, and returns inst_out=0x1140. Afterwards pc=0x100 hits.
- Flush mid-refill: miss at 0x300, flush=1 in the 2nd REFILL cycle → next cycle mem_rd_en=0 and state IDLE. 0x300 re-misses with a full 4-read refill. Previously cached 0x100 also misses.
- Async reset mid-refill: assert rst between clock edges during REFILL → mem_rd_en=0, counters=0, inst_out=NOP immediately. After release, pc=0x100 misses.

Source files
------------

// File: rtl/icache_direct.sv
// Direct-mapped, read-only, blocking instruction cache: combinational hit path,
// whole-line refill from a 1-cycle-latency block RAM, flush and perf counters.
module icache_direct #(
    parameter int          LINES = 16,
    parameter int          WORDS = 4,
    parameter logic [31:0] NOP   = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req,
    input  logic [31:0] pc_in,
    input  logic        flush,
    output logic [31:0] inst_out,
    output logic        stall,
    output logic [31:0] mem_addr,
    output logic        mem_rd_en,
    input  logic [31:0] mem_data,
    output logic [31:0] hit_count,
    output logic [31:0] miss_count
);

    localparam int OFF_W = $clog2(WORDS);
    localparam int IDX_W = $clog2(LINES);
    localparam int TAG_W = 30 - OFF_W - IDX_W;
    localparam int CNT_W = OFF_W + 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WORDS - 1);
    localparam logic [OFF_W-1:0] LAST_OFF = OFF_W'(WORDS - 1);

    typedef enum logic [1:0] {IDLE, REFILL, LAST} state_t;

    state_t             state;
    logic [CNT_W-1:0]   cnt;
    logic [TAG_W-1:0]   base_tag;
    logic [IDX_W-1:0]   base_idx;
    logic [LINES-1:0]   valid;
    logic [TAG_W-1:0]   tags [LINES];
    logic [31:0]        data [LINES*WORDS];

    logic [OFF_W-1:0]   pc_off;
    logic [IDX_W-1:0]   pc_idx;
    logic [TAG_W-1:0]   pc_tag;
    logic [OFF_W-1:0]   fill_off;
    logic               hit;
    logic               unused_pc_bits;

    assign pc_off = pc_in[OFF_W+1:2];
    assign pc_idx = pc_in[OFF_W+IDX_W+1:OFF_W+2];
    assign pc_tag = pc_in[31:OFF_W+IDX_W+2];
    assign unused_pc_bits = &{1'b0, pc_in[1:0]};

    // The word returning during a REFILL cycle belongs to the previous issue.
    assign fill_off = OFF_W'(cnt - CNT_W'(1));

    // A flushing lookup never hits: the line is about to be invalidated.
    assign hit = req && (state == IDLE) && !flush && valid[pc_idx]
                 && (tags[pc_idx] == pc_tag);

    assign inst_out = hit ? data[{pc_idx, pc_off}] : NOP;
    assign stall    = req && !hit;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= '0;
            base_tag   <= '0;
            base_idx   <= '0;
            valid      <= '0;
            mem_rd_en  <= 1'b0;
            mem_addr   <= '0;
            hit_count  <= '0;
            miss_count <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (flush) begin
                        valid <= '0;
                    end else if (req && !hit) begin
                        base_tag  <= pc_tag;
                        base_idx  <= pc_idx;
                        mem_addr  <= {pc_tag, pc_idx, {(OFF_W+2){1'b0}}};
                        mem_rd_en <= 1'b1;
                        cnt       <= '0;
                        state     <= REFILL;
                        if (miss_count != 32'hFFFF_FFFF)
                            miss_count <= miss_count + 32'd1;
                    end else if (hit) begin
                        if (hit_count != 32'hFFFF_FFFF)
                            hit_count <= hit_count + 32'd1;
                    end
                end
                REFILL: begin
                    if (flush) begin
                        valid     <= '0;
                        mem_rd_en <= 1'b0;
                        state     <= IDLE;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                        if (cnt == LAST_CNT) begin
                            mem_rd_en <= 1'b0;
                            state     <= LAST;
                        end else begin
                            mem_addr <= mem_addr + 32'd4;
                        end
                    end
                end
                LAST: begin
                    if (flush)
                        valid <= '0;
                    else
                        valid[base_idx] <= 1'b1;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Line storage needs no reset; only the valid bits qualify its contents.
    always_ff @(posedge clk) begin
        if (state == REFILL && !flush && cnt != '0)
            data[{base_idx, fill_off}] <= mem_data;
        if (state == LAST && !flush) begin
            data[{base_idx, LAST_OFF}] <= mem_data;
            tags[base_idx]             <= base_tag;
        end
    end

endmodule
